// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control FSM and its instruction decoder.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned TMO_W    = 8;
    localparam int unsigned PERF_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 2'b00,
        ALU_CMP   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_R      = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } instr_cls_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       valid;
        instr_cls_e cls;
    } decode_t;

    // Classify an opcode; anything outside the four supported groups is invalid.
    function automatic decode_t decode_opcode(input logic [OPCODE_W-1:0] op);
        decode_t d;
        d.valid = 1'b1;
        d.cls   = CLS_R;
        case (op)
            OP_RTYPE:  d.cls = CLS_R;
            OP_LOAD:   d.cls = CLS_LOAD;
            OP_STORE:  d.cls = CLS_STORE;
            OP_BRANCH: d.cls = CLS_BRANCH;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Memory wait-cycle counter; hit_c flags the cycle in which one more unready cycle reaches LIMIT.
module ctrl_timeout_cnt
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit_c
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMO_W'(1);
        end
    end

    // Compared against LIMIT-1 so a ready arriving in the hit cycle still wins.
    assign hit_c = (count == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout and sticky FAULT.
// Optional macro CPU_CTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [OPCODE_W-1:0] opcode_in,
    input  logic                branch_taken_in,
    input  logic                mem_ready_in,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic                mem_addr_sel_out,
    output logic                ir_we_out,
    output logic                pc_we_out,
    output logic                pc_src_out,
    output logic                alu_src_out,
    output logic [ALU_OP_W-1:0] alu_op_out,
    output logic                rf_we_out,
    output logic                wb_sel_out,
    output logic [STATE_W-1:0]  state_out,
    output logic                retire_out,
    output logic                fault_out
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   cycle_cnt_out,
    output logic [PERF_W-1:0]   retired_cnt_out
`endif
);

    state_e     state_q;
    state_e     state_d;
    instr_cls_e cls_q;
    decode_t    dec;
    logic       mem_wait;
    logic       tmo_hit;

    always_comb begin
        dec = decode_opcode(opcode_in);
    end

    assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Counter is cleared outside the memory states and on every completed transfer.
    ctrl_timeout_cnt #(
        .LIMIT (MEM_TIMEOUT)
    ) u_tmo (
        .clk   (clk_in),
        .rst   (rst_in),
        .clr   (!mem_wait || mem_ready_in),
        .en    (mem_wait && !mem_ready_in),
        .hit_c (tmo_hit)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction class captured in DECODE so later opcode changes are ignored.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cls_q <= CLS_R;
        end else if (state_q == ST_DECODE && dec.valid) begin
            cls_q <= dec.cls;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready_in) begin
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_d = dec.valid ? ST_EXEC : ST_FAULT;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R:      state_d = ST_WB;
                    CLS_LOAD:   state_d = ST_MEM;
                    CLS_STORE:  state_d = ST_MEM;
                    CLS_BRANCH: state_d = ST_FETCH;
                    default:    state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_in) begin
                    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (tmo_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // Moore decode from state, qualified by ready/branch_taken; everything held low in reset.
    always_comb begin
        mem_req_out      = 1'b0;
        mem_we_out       = 1'b0;
        mem_addr_sel_out = 1'b0;
        ir_we_out        = 1'b0;
        pc_we_out        = 1'b0;
        pc_src_out       = 1'b0;
        alu_src_out      = 1'b0;
        alu_op_out       = ALU_ADD;
        rf_we_out        = 1'b0;
        wb_sel_out       = 1'b0;
        retire_out       = 1'b0;
        fault_out        = 1'b0;
        if (!rst_in) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req_out = 1'b1;
                    if (mem_ready_in) begin
                        ir_we_out = 1'b1;
                        pc_we_out = 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_R: begin
                            alu_op_out = ALU_FUNCT;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_src_out = 1'b1;
                            alu_op_out  = ALU_ADD;
                        end
                        CLS_BRANCH: begin
                            alu_op_out = ALU_CMP;
                            pc_we_out  = branch_taken_in;
                            pc_src_out = 1'b1;
                            retire_out = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req_out      = 1'b1;
                    mem_addr_sel_out = 1'b1;
                    mem_we_out       = (cls_q == CLS_STORE);
                    retire_out       = mem_ready_in && (cls_q == CLS_STORE);
                end
                ST_WB: begin
                    rf_we_out  = 1'b1;
                    wb_sel_out = (cls_q == CLS_LOAD);
                    retire_out = 1'b1;
                end
                ST_FAULT: begin
                    fault_out = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_out = state_q;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cycle_cnt_q;
    logic [PERF_W-1:0] retired_cnt_q;

    // Both counters freeze once the FSM is stuck in FAULT.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else if (state_q != ST_FAULT) begin
            cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
            if (retire_out) begin
                retired_cnt_q <= retired_cnt_q + PERF_W'(1);
            end
        end
    end

    assign cycle_cnt_out   = cycle_cnt_q;
    assign retired_cnt_out = retired_cnt_q;
`endif

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max cycles mem_req_out may wait for mem_ready_in before FAULT (range 1..255).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_in  in  1  sole clock, rising edge.
REQ-004 rst_in  in  1  synchronous active-high reset.
REQ-005 opcode_in  in  7  opcode from instruction decoder.
REQ-006 branch_taken_in  in  1  datapath branch-compare result, valid in EXEC.
REQ-007 mem_ready_in  in  1  memory completes the current request this cycle.
REQ-008 mem_req_out  out  1  memory request, held until accepted.
REQ-009 mem_we_out  out  1  request is a store.
REQ-010 mem_addr_sel_out  out  1  0 = PC address, 1 = ALU result address.
REQ-011 ir_we_out  out  1  load instruction register.
REQ-012 pc_we_out  out  1  write PC.
REQ-013 pc_src_out  out  1  0 = PC+4, 1 = branch target.
REQ-014 alu_src_out  out  1  0 = rs2, 1 = imm.
REQ-015 alu_op_out  out  2  00 add, 01 compare, 10 funct3/funct7 decode.
REQ-016 rf_we_out  out  1  register-file write.
REQ-017 wb_sel_out  out  1  0 = ALU, 1 = memory data.
REQ-018 state_out  out  3  current state encoding.
REQ-019 retire_out  out  1  one-cycle pulse per retired instruction.
REQ-020 fault_out  out  1  sticky fault flag.

Function
REQ-021 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7; all outputs Moore-decoded from state, except the pc_we_out/ir_we_out/retire_out qualifiers below.
REQ-022 FETCH: mem_req_out=1, mem_addr_sel_out=0; on mem_ready_in: ir_we_out=1, pc_we_out=1, pc_src_out=0, next DECODE; else stay.
REQ-023 DECODE: 1 cycle; R-type 0110011, load 0000011, store 0100011, branch 1100011 -> EXEC; any other opcode -> FAULT.
REQ-024 EXEC, R-type: alu_src_out=0, alu_op_out=10, next WB.
REQ-025 EXEC, load/store: alu_src_out=1, alu_op_out=00, next MEM.
REQ-026 EXEC, branch: alu_op_out=01; pc_we_out=branch_taken_in, pc_src_out=1; retire_out=1; next FETCH.
REQ-027 MEM: mem_req_out=1, mem_addr_sel_out=1, mem_we_out=1 for store only; on mem_ready_in: load -> WB, store -> FETCH with retire_out=1.
REQ-028 WB: rf_we_out=1, wb_sel_out=1 for load else 0, retire_out=1, next FETCH.
REQ-029 Cycle counts: R 4+F, load 5+F+M, store 4+F+M, branch 3+F (F, M = wait cycles before ready).
REQ-030 Handshake: transfer occurs only when mem_req_out and mem_ready_in are both high; mem_ready_in with mem_req_out low is ignored.
REQ-031 Opcode is latched in DECODE; opcode_in changes after DECODE have no effect.
REQ-032 Timeout counter clears on entry to FETCH/MEM and increments each unready cycle; reaching MEM_TIMEOUT -> FAULT.
REQ-033 A mem_ready_in arriving in the same cycle the count reaches MEM_TIMEOUT wins; no fault.
REQ-034 FAULT: all strobes 0, fault_out=1, exits only via reset.

Reset
REQ-035 rst_in high at a clock edge: next state FETCH, timeout counter 0, fault_out 0.
REQ-036 While rst_in is high, all outputs except state_out are forced 0, including mid-transaction (mem_req_out drops the same cycle).
REQ-037 First cycle after reset release: FETCH with mem_req_out=1.

Configuration
REQ-038 Macro CPU_CTRL_PERF_CNT_EN defined: adds outputs cycle_cnt_out[31:0] (increments every non-reset cycle) and retired_cnt_out[31:0] (increments on retire_out); both reset to 0, wrap at 2^32, freeze in FAULT.
REQ-039 Macro undefined: neither port nor counter exists; all other behaviour is identical.

Structure
REQ-040 Package cpu_ctrl_pkg SHALL hold the state enum, opcode constants and alu_op enum; the instruction decoder shares the opcode constants.
REQ-041 Sub-module ctrl_timeout_cnt (8-bit counter with clear, enable, hit) is used for REQ-032.

Verification
REQ-042 R-type 0110011, mem_ready_in tied high -> states 0,1,2,4,0; rf_we_out=1 only in WB; retire once per 4 cycles.
REQ-043 Load with FETCH ready delayed 2 cycles, MEM ready delayed 3 -> 10 cycles to retire; wb_sel_out=1 in WB.
REQ-044 Branch, branch_taken_in=1 then 0 -> pc_we_out=1 with pc_src_out=1 in first EXEC, pc_we_out=0 in second EXEC.
REQ-045 Opcode 1111111 -> FAULT after DECODE; fault_out stays high 20 cycles; reset -> FETCH.
REQ-046 MEM_TIMEOUT=4, ready never asserted -> FAULT after 4 FETCH cycles; repeat with ready on cycle 4 -> no fault.
REQ-047 rst_in pulsed mid-MEM store -> mem_req_out and mem_we_out drop the same cycle, no retire; with CPU_CTRL_PERF_CNT_EN, both counters read 0.
